// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out
// one bit per clock with a per-bit valid and an end-of-word marker. A new word
// can be accepted on the cycle that carries the last bit of the current one,
// so consecutive words leave as an unbroken bit stream.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk      rising-edge clock
//   reset_   asynchronous active-low reset
//   i_data   parallel word, sampled on a handshake edge only
//   i_valid  source offers a word
//   i_ready  block can take a word this cycle (combinational from state)
//   o        serial data bit (idle level 0)
//   o_valid  o carries a word bit this cycle
//   o_last   this cycle carries the final bit of the word
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             o,
  output logic             o_valid,
  output logic             o_last
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             xfer;

  // Move the word one place toward the output end, zero fill behind it.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return {v[WIDTH-2:0], 1'b0};
    else                return {1'b0, v[WIDTH-1:1]};
  endfunction

  // Outputs come straight from registered state; the only input-dependent
  // signal is xfer, which feeds next-state logic only.
  assign o_valid = (state == SHIFT);
  assign o_last  = o_valid && (cnt == CNT_LAST);
  assign i_ready = !o_valid || o_last;
  assign xfer    = i_valid && i_ready;
  assign o       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    if (xfer) begin
      // Covers both an idle load and a back-to-back load on the last bit.
      state_nx = SHIFT;
      shreg_nx = i_data;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          // Hold; shreg is already zero so the line sits at 0.
        end
        SHIFT: begin
          if (o_last) begin
            state_nx = IDLE;
            shreg_nx = '0;
            cnt_nx   = '0;
          end else begin
            shreg_nx = shift_toward_out(shreg);
            cnt_nx   = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          shreg_nx = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- bench for piso_tx.
//
// Three instances: A (WIDTH=4, MSB first), B (WIDTH=4, LSB first) and
// C (WIDTH=8, MSB first). The reference model is a queue of bits still to be
// sent per instance: an accepted word appends its bits in send order, every
// edge consumes the bit on the line, and the outputs follow from the queue
// length (empty = idle, one entry = last bit, at most one entry = ready).
module tb_piso_tx;

  logic       clk;
  logic       reset_;

  logic [3:0] da, db;
  logic [7:0] dc;
  logic       va, vb, vc;
  logic       ira, irb, irc;
  logic       oa, ob, oc;
  logic       ova, ovb, ovc;
  logic       ola, olb, olc;

  int checks;
  int passed;

  bit qa[$];
  bit qb[$];
  bit qc[$];
  logic acc_a;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .reset_(reset_), .i_data(da), .i_valid(va), .i_ready(ira),
    .o(oa), .o_valid(ova), .o_last(ola)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_b (
    .clk(clk), .reset_(reset_), .i_data(db), .i_valid(vb), .i_ready(irb),
    .o(ob), .o_valid(ovb), .o_last(olb)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1)) u_c (
    .clk(clk), .reset_(reset_), .i_data(dc), .i_valid(vc), .i_ready(irc),
    .o(oc), .o_valid(ovc), .o_last(olc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {o, o_valid, o_last, i_ready} from a pending-bit queue.
  function automatic logic [3:0] exp_from(input int size, input bit head);
    if (size == 0) return 4'b0001;
    return {head, 1'b1, (size == 1), (size == 1)};
  endfunction

  function automatic logic [3:0] exp_a();
    return exp_from(qa.size(), (qa.size() > 0) ? qa[0] : 1'b0);
  endfunction
  function automatic logic [3:0] exp_b();
    return exp_from(qb.size(), (qb.size() > 0) ? qb[0] : 1'b0);
  endfunction
  function automatic logic [3:0] exp_c();
    return exp_from(qc.size(), (qc.size() > 0) ? qc[0] : 1'b0);
  endfunction

  // Reference model step for one rising edge, using inputs as seen at the edge.
  task automatic model_edge();
    logic ra, rb, rc;
    if (!reset_) begin
      qa.delete(); qb.delete(); qc.delete();
      acc_a = 1'b0;
      return;
    end
    ra = (qa.size() <= 1);
    rb = (qb.size() <= 1);
    rc = (qc.size() <= 1);
    acc_a = va && ra;
    if (qa.size() > 0) void'(qa.pop_front());
    if (qb.size() > 0) void'(qb.pop_front());
    if (qc.size() > 0) void'(qc.pop_front());
    if (acc_a)     for (int n = 0; n < 4; n++) qa.push_back(da[3-n]);
    if (vb && rb)  for (int n = 0; n < 4; n++) qb.push_back(db[n]);
    if (vc && rc)  for (int n = 0; n < 8; n++) qc.push_back(dc[7-n]);
  endtask

  // One clock: edge, model update, then back to the sampling point (negedge).
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    da = '0; db = '0; dc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({oa, ova, ola, ira} !== 4'b0001) $display("FAIL reset_a: got %b expected %b", {oa, ova, ola, ira}, 4'b0001);
    else passed++;
    checks++;
    if ({ob, ovb, olb, irb} !== 4'b0001) $display("FAIL reset_b: got %b expected %b", {ob, ovb, olb, irb}, 4'b0001);
    else passed++;
    checks++;
    if ({oc, ovc, olc, irc} !== 4'b0001) $display("FAIL reset_c: got %b expected %b", {oc, ovc, olc, irc}, 4'b0001);
    else passed++;
    reset_ = 1'b1;
    tick();
    tick();
    checks++;
    if ({oa, ova, ola, ira} !== 4'b0001) $display("FAIL reset_release_a: got %b expected %b", {oa, ova, ola, ira}, 4'b0001);
    else passed++;
  endtask

  task automatic test_single();
    logic [3:0] col;
    int nv;
    col = '0; nv = 0;
    va = 1'b1; da = 4'b1011;
    tick();
    va = 1'b0; da = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL single_cyc%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
      if (ova) begin col = {col[2:0], oa}; nv++; end
      tick();
    end
    checks++;
    if (col !== 4'b1011 || nv != 4) $display("FAIL single_word: got %b/%0d bits expected 1011/4 bits", col, nv);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] col;
    int nv;
    col = '0; nv = 0;
    va = 1'b1; da = 4'b1011;
    tick();
    da = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      va = (i < 4);
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL b2b_cyc%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
      if (ova) begin col = {col[6:0], oa}; nv++; end
      tick();
    end
    checks++;
    if (col !== 8'b10110110 || nv != 8) $display("FAIL b2b_stream: got %b/%0d bits expected 10110110/8 bits", col, nv);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    logic [7:0] col;
    col = '0;
    va = 1'b1; da = 4'b1100;
    tick();
    da = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      va = (i <= 3);
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL busy_cyc%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
      if (i < 3) begin
        checks++;
        if (ira !== 1'b0) $display("FAIL busy_ready%0d: got %b expected 0", i, ira);
        else passed++;
      end
      if (ova) col = {col[6:0], oa};
      tick();
    end
    checks++;
    if (col !== 8'b11000011) $display("FAIL busy_stream: got %b expected 11000011", col);
    else passed++;
  endtask

  task automatic test_lsb_first();
    logic [3:0] col;
    col = '0;
    vb = 1'b1; db = 4'b1011;
    tick();
    vb = 1'b0; db = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({ob, ovb, olb, irb} !== exp_b()) $display("FAIL lsb_cyc%0d: got %b expected %b", i, {ob, ovb, olb, irb}, exp_b());
      else passed++;
      if (ovb) col = {col[2:0], ob};
      tick();
    end
    checks++;
    if (col !== 4'b1101) $display("FAIL lsb_word: got %b expected 1101", col);
    else passed++;
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] col;
    col = '0;
    va = 1'b1; da = 4'b1111;
    tick();
    va = 1'b0;
    tick();
    tick();
    // now in the cycle carrying bit 2
    checks++;
    if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL midrst_bit2: got %b expected %b", {oa, ova, ola, ira}, exp_a());
    else passed++;
    #1 reset_ = 1'b0;
    qa.delete();
    #1;
    checks++;
    if ({oa, ova, ola, ira} !== 4'b0001) $display("FAIL midrst_async: got %b expected %b", {oa, ova, ola, ira}, 4'b0001);
    else passed++;
    // a word offered while reset is held must not be taken
    va = 1'b1; da = 4'($urandom);
    tick();
    checks++;
    if ({oa, ova, ola, ira} !== 4'b0001) $display("FAIL midrst_held: got %b expected %b", {oa, ova, ola, ira}, 4'b0001);
    else passed++;
    va = 1'b0;
    reset_ = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL midrst_idle%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
    end
    va = 1'b1; da = 4'b1001;
    tick();
    va = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL midrst_new%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
      if (ova) col = {col[2:0], oa};
      tick();
    end
    checks++;
    if (col !== 4'b1001) $display("FAIL midrst_word: got %b expected 1001", col);
    else passed++;
  endtask

  task automatic test_wide();
    logic [7:0] col;
    int nl;
    col = '0; nl = 0;
    vc = 1'b1; dc = 8'hA5;
    tick();
    vc = 1'b0; dc = 8'h00;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({oc, ovc, olc, irc} !== exp_c()) $display("FAIL wide_cyc%0d: got %b expected %b", i, {oc, ovc, olc, irc}, exp_c());
      else passed++;
      if (ovc) col = {col[6:0], oc};
      if (olc) nl = i;
      tick();
    end
    checks++;
    if (col !== 8'hA5 || nl != 7) $display("FAIL wide_word: got %h last@%0d expected a5 last@7", col, nl);
    else passed++;
  endtask

  task automatic test_random();
    va = 1'b0;
    acc_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      // a pending offer is held until it is taken
      if (!va || acc_a) begin
        va = 1'($urandom_range(0, 1));
        da = 4'($urandom);
      end
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL rand_cyc%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
      tick();
    end
    va = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({oa, ova, ola, ira} !== exp_a()) $display("FAIL rand_drain%0d: got %b expected %b", i, {oa, ova, ola, ira}, exp_a());
      else passed++;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    acc_a  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_lsb_first();
    test_reset_mid_word();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
